// File: rtl/controlador_varredura_matriz_pkg.sv
// Shared types and constants for the LED dot-matrix scan controller.
// Holds the scan state encoding, the row register width and a counter width helper.
package controlador_varredura_matriz_pkg;

   localparam int LARGURA_LINHA = 7;

   typedef enum logic [2:0] {
      OCIOSO,
      CARGA,
      DESLOCA,
      TRAVA,
      ESPERA
   } estado_t;

   // A modulo-1 counter still needs one bit of storage.
   function automatic int largura_contador(input int modulo);
      return (modulo < 2) ? 1 : $clog2(modulo);
   endfunction

endpackage

// File: rtl/controlador_varredura_matriz_contador.sv
// Modulo-M up counter with enable and terminal-count flag.
// Wraps from M-1 straight to 0, so it never needs a synchronous clear.
module contador_modulo
   import controlador_varredura_matriz_pkg::*;
#(
   parameter int M = 4,
   parameter int W = largura_contador(M)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         incrementa,
   output logic [W-1:0] contagem,
   output logic         terminal
);

   localparam logic [W-1:0] ULTIMO = W'(M - 1);

   logic [W-1:0] contagem_q;
   logic [W-1:0] contagem_d;

   assign terminal = (contagem_q == ULTIMO);
   assign contagem = contagem_q;

   always_comb begin
      contagem_d = contagem_q;
      if (incrementa) begin
         contagem_d = terminal ? '0 : contagem_q + W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, with the
   // asynchronous reset as the sole condition ahead of the clocked update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         contagem_q <= '0;
      end else begin
         contagem_q <= contagem_d;
      end
   end

endmodule

// File: rtl/controlador_varredura_matriz.sv
// Column scan sequencer for the 7x5 dot-matrix: load, shift, latch, then dwell
// on one column before advancing; columns stay blank outside the dwell phase.
module controlador_varredura_matriz
   import controlador_varredura_matriz_pkg::*;
#(
   parameter int N_COLS = 5,
   parameter int DIV    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      habilita,
   output logic                      sinal,
   output logic                      desloca,
   output logic                      trava,
   output logic [$clog2(N_COLS)-1:0] indice_coluna,
   output logic [N_COLS-1:0]         colunas,
   output logic                      fim_quadro,
   output logic                      ocupado
);

   localparam int W_BIT = largura_contador(LARGURA_LINHA);
   localparam int W_DIV = largura_contador(DIV);
   localparam int W_IDX = $clog2(N_COLS);

   estado_t estado_q, estado_d;
   logic    sinal_q, sinal_d;
   logic    desloca_q, desloca_d;
   logic    trava_q, trava_d;
   logic    fim_quadro_q, fim_quadro_d;
   logic    ocupado_q, ocupado_d;

   logic             bit_fim, espera_fim, coluna_fim;
   logic [W_BIT-1:0] contagem_bit_unused;
   logic [W_DIV-1:0] contagem_espera_unused;

   contador_modulo #(.M(LARGURA_LINHA), .W(W_BIT)) u_contador_bit (
      .clk        (clk),
      .reset      (reset),
      .incrementa (estado_q == DESLOCA),
      .contagem   (contagem_bit_unused),
      .terminal   (bit_fim)
   );

   contador_modulo #(.M(DIV), .W(W_DIV)) u_contador_espera (
      .clk        (clk),
      .reset      (reset),
      .incrementa (estado_q == ESPERA),
      .contagem   (contagem_espera_unused),
      .terminal   (espera_fim)
   );

   contador_modulo #(.M(N_COLS), .W(W_IDX)) u_contador_coluna (
      .clk        (clk),
      .reset      (reset),
      .incrementa ((estado_q == ESPERA) && espera_fim),
      .contagem   (indice_coluna),
      .terminal   (coluna_fim)
   );

   // Outputs are decoded from the next state so they line up with estado_q.
   always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
         OCIOSO:  if (habilita) estado_d = CARGA;
         CARGA:   estado_d = DESLOCA;
         DESLOCA: if (bit_fim) estado_d = TRAVA;
         TRAVA:   estado_d = ESPERA;
         ESPERA:  if (espera_fim) estado_d = habilita ? CARGA : OCIOSO;
         default: estado_d = OCIOSO;
      endcase

      sinal_d      = (estado_d == CARGA);
      desloca_d    = (estado_d == CARGA) || (estado_d == DESLOCA);
      trava_d      = (estado_d == TRAVA);
      ocupado_d    = (estado_d != OCIOSO);
      fim_quadro_d = (estado_q == ESPERA) && espera_fim && coluna_fim;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q     <= OCIOSO;
         sinal_q      <= 1'b0;
         desloca_q    <= 1'b0;
         trava_q      <= 1'b0;
         fim_quadro_q <= 1'b0;
         ocupado_q    <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         sinal_q      <= sinal_d;
         desloca_q    <= desloca_d;
         trava_q      <= trava_d;
         fim_quadro_q <= fim_quadro_d;
         ocupado_q    <= ocupado_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no latch forms.
   always_comb begin
      colunas = '0;
      if (estado_q == ESPERA) begin
         colunas[indice_coluna] = 1'b1;
      end
   end

   assign sinal      = sinal_q;
   assign desloca    = desloca_q;
   assign trava      = trava_q;
   assign fim_quadro = fim_quadro_q;
   assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_controlador_varredura_matriz.sv
// Scoreboard bench for the scan controller: expected output vectors are queued
// as stimulus is driven and compared on the falling edge.
module tb_controlador_varredura_matriz;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, hab_a;
   logic       sinal_a, desloca_a, trava_a, fim_a, ocup_a;
   logic [2:0] idx_a;
   logic [4:0] col_a;

   logic       reset_b, hab_b;
   logic       sinal_b, desloca_b, trava_b, fim_b, ocup_b;
   logic [0:0] idx_b;
   logic [1:0] col_b;

   controlador_varredura_matriz #(.N_COLS(5), .DIV(4)) dut_a (
      .clk           (clk),
      .reset         (reset_a),
      .habilita      (hab_a),
      .sinal         (sinal_a),
      .desloca       (desloca_a),
      .trava         (trava_a),
      .indice_coluna (idx_a),
      .colunas       (col_a),
      .fim_quadro    (fim_a),
      .ocupado       (ocup_a)
   );

   controlador_varredura_matriz #(.N_COLS(2), .DIV(1)) dut_b (
      .clk           (clk),
      .reset         (reset_b),
      .habilita      (hab_b),
      .sinal         (sinal_b),
      .desloca       (desloca_b),
      .trava         (trava_b),
      .indice_coluna (idx_b),
      .colunas       (col_b),
      .fim_quadro    (fim_b),
      .ocupado       (ocup_b)
   );

   // Vector layout: {sinal, desloca, trava, ocupado, fim_quadro, indice[2:0], colunas[4:0]}
   typedef logic [12:0] vec_t;

   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   sel_b    = 1'b0;
   int   cfg_div  = 4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: observed %b expected %b", tag, $time, obs[12:0], exp[12:0]);
      end
   endtask

   function automatic vec_t vec(input bit s, input bit d, input bit t, input bit oc,
                                input bit fim, input int idx, input int col);
      return {s, d, t, oc, fim, 3'(idx), 5'(col)};
   endfunction

   function automatic vec_t atual();
      if (sel_b)
         return {sinal_b, desloca_b, trava_b, ocup_b, fim_b, 2'b00, idx_b, 3'b000, col_b};
      return {sinal_a, desloca_a, trava_a, ocup_a, fim_a, idx_a, col_a};
   endfunction

   always @(negedge clk) begin
      vec_t a;
      vec_t e;
      a = atual();
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("saidas", 32'(a), 32'(e));
      end
      if (|a[12:10]) check("apagamento", 32'(a[4:0]), 32'd0);
   end

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic set_hab(input bit v);
      if (sel_b) hab_b = v;
      else       hab_a = v;
   endtask

   task automatic ocioso(input int idx, input bit fim);
      ciclo();
      exp_q.push_back(vec(0, 0, 0, 0, fim, idx, 0));
   endtask

   // One column as seen from outside: load, 7 shifts, latch, dwell on the column.
   task automatic coluna(input int idx, input bit fim, input int drop = -1, input int n_esp = -1);
      int ne;
      ne = (n_esp < 0) ? cfg_div : n_esp;
      ciclo();
      exp_q.push_back(vec(1, 1, 0, 1, fim, idx, 0));
      for (int i = 0; i < 7; i++) begin
         ciclo();
         exp_q.push_back(vec(0, 1, 0, 1, 0, idx, 0));
         if (i == drop) set_hab(1'b0);
      end
      ciclo();
      exp_q.push_back(vec(0, 0, 1, 1, 0, idx, 0));
      for (int i = 0; i < ne; i++) begin
         ciclo();
         exp_q.push_back(vec(0, 0, 0, 1, 0, idx, 1 << idx));
      end
   endtask

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      hab_a   = 1'b0;
      hab_b   = 1'b0;

      ocioso(0, 0);
      ocioso(0, 0);

      ciclo();
      reset_a = 1'b0;
      hab_a   = 1'b1;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0));

      // First column after reset, then a full frame and the 4->0 wrap.
      coluna(0, 0);
      for (int c = 1; c < 5; c++) coluna(c, 0);
      coluna(0, 1);
      coluna(1, 0);

      // habilita drops mid-shift of column 2; the column still completes.
      coluna(2, 0, 3);
      ocioso(3, 0);
      ocioso(3, 0);
      ciclo();
      hab_a = 1'b1;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 3, 0));

      // Restart resumes at column 3; reset lands inside its dwell.
      coluna(3, 0, -1, 2);
      @(posedge clk);
      #2;
      reset_a = 1'b1;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0));
      ocioso(0, 0);
      ciclo();
      reset_a = 1'b0;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0));

      // Ten frames from column 0, blanking checked every cycle by the monitor.
      for (int f = 0; f < 10; f++)
         for (int c = 0; c < 5; c++)
            coluna(c, (c == 0) && (f != 0));

      // Corner instance: DIV=1, N_COLS=2.
      ciclo();
      hab_a   = 1'b0;
      sel_b   = 1'b1;
      cfg_div = 1;
      reset_b = 1'b0;
      hab_b   = 1'b1;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0));
      for (int f = 0; f < 3; f++)
         for (int c = 0; c < 2; c++)
            coluna(c, (c == 0) && (f != 0));

      @(negedge clk);
      #1;
      check("fila_vazia", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/controlador_varredura_matriz.md
# controlador_varredura_matriz

Scan controller for the 7×5 LED dot-matrix display. It sequences the 7-bit parallel-load row shift register: load one column pattern, shift it out serially, latch it, then drive that column for a dwell time before moving to the next column. It sits between the character/column pattern source and the row register plus column drivers. It replaces the free-running column ring as the source of the register's load/shift select.

## Interface
Parameters:
- N_COLS, 5, number of display columns scanned per frame (≥2)
- DIV, 16, dwell cycles per column with the column driver on (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- habilita  in  1  run enable; sampled in OCIOSO and at end of each column
- sinal  out  1  row-register mode select: 1 = parallel load of column bits, 0 = serial shift
- desloca  out  1  row-register clock enable
- trava  out  1  one-cycle pulse latching shifted row data into drivers
- indice_coluna  out  $clog2(N_COLS)  current column index, 0..N_COLS-1; selects external pattern source
- colunas  out  N_COLS  one-hot column drive, active-high
- fim_quadro  out  1  one-cycle pulse when the last column finishes
- ocupado  out  1  high whenever state ≠ OCIOSO

## Operation
- States: OCIOSO, CARGA, DESLOCA, TRAVA, ESPERA.
- OCIOSO:
  - All control outputs are 0.
  - Go to CARGA on the cycle after habilita=1 is sampled.
- CARGA (1 cycle):
  - sinal=1, desloca=1.
  - The register loads the external 7-bit pattern for indice_coluna.
- DESLOCA (7 cycles):
  - sinal=0, desloca=1.
  - Bit counter runs 0..6; leave when it equals 6.
- TRAVA (1 cycle): trava=1, desloca=0.
- ESPERA (DIV cycles):
  - colunas[indice_coluna]=1.
  - Dwell counter runs 0..DIV-1.
- End of ESPERA:
  - indice_coluna increments, wrapping N_COLS-1 → 0.
  - At the wrap, fim_quadro=1 for exactly one cycle, coincident with the first cycle of the next state.
  - Next state is CARGA if habilita=1, else OCIOSO.
- Column blanking: colunas is all-zero in every state except ESPERA, so no ghosting occurs while shifting.
- habilita dropping mid-column does not abort. The current column completes through ESPERA, then the block goes to OCIOSO with the index already advanced.
- Restart from OCIOSO resumes at the held indice_coluna; it does not return to 0.
- habilita is ignored in CARGA, DESLOCA and TRAVA.

## Timing
- Reset value of every output is 0; state is OCIOSO, counters are 0.
- Reset asserted mid-operation clears everything immediately. No partial trava or fim_quadro pulse is produced after reset deasserts.
- Column period: 1 + 7 + 1 + DIV = DIV+9 cycles.
- Frame period: N_COLS·(DIV+9) cycles.
- Start latency: habilita sampled high in OCIOSO gives CARGA on the next cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from habilita to any output.
- Counter widths:
  - bit counter: 3 bits
  - dwell counter: $clog2(DIV) bits, minimum 1
  - index: $clog2(N_COLS) bits
  - All compares are equality-to-terminal; no overflow is possible.

## Structure
- Shared package holds:
  - the state enum (OCIOSO, CARGA, DESLOCA, TRAVA, ESPERA)
  - constant LARGURA_LINHA = 7 (row register width, and shift count)
- One natural sub-module: contador_modulo, a parameterized modulo-M counter with enable, terminal-count flag and async reset. Instantiate it three times: bit counter (M=7), dwell (M=DIV), column index (M=N_COLS).
- One-hot colunas is decoded from indice_coluna, gated by state==ESPERA.

## Test plan
Use DIV=4, N_COLS=5 for all scenarios.
- Reset then habilita=1 held:
  - sinal=1 for exactly 1 cycle, then desloca=1 with sinal=0 for 7 cycles, then trava for 1 cycle.
  - colunas=00001 for 4 cycles.
  - Column period is 13 cycles.
- Full frame:
  - indice_coluna steps 0,1,2,3,4,0.
  - colunas one-hot steps 00001 through 10000.
  - Exactly one fim_quadro pulse per 65 cycles, at the 4→0 wrap.
- habilita dropped during DESLOCA of column 2:
  - Column 2 completes, including 4 cycles of colunas=00100.
  - Block then goes to OCIOSO with indice_coluna=3 and ocupado=0.
  - Re-raising habilita starts at column 3.
- Reset pulsed during ESPERA of column 3:
  - All outputs are 0 in the same cycle, asynchronously.
  - After release with habilita=1, scanning starts at column 0.
  - No stray trava or fim_quadro.
- Blanking check over 10 frames: colunas is never nonzero while sinal, desloca or trava is 1.
- DIV=1, N_COLS=2 corner case: column period is 10 cycles, and fim_quadro pulses every 20 cycles.
